ex_muldiv_unit: RTL and testbench

Sequential multiply/divide unit in the EX stage. It consumes operands and a mul/div opcode from the ID/EX pipeline register outputs, after the forwarding muxes. It produces 64-bit HI/LO results. While an operation is in flight, it raises a stall request that freezes PC, IF/ID and ID/EX. MFHI/MFLO paths read hi/lo combinationally from this unit's registers.

---
 rtl/ex_muldiv_unit.sv | 214 +++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative multiply/divide unit in the EX stage of a MIPS-style pipeline.
// It handles MULT, MULTU, DIV and DIVU. Each operation takes one issue
// cycle, DATA_LEN iteration cycles and one DONE cycle. The unit holds the
// pipeline for the whole operation. A divide by zero skips the iterations
// and goes directly to DONE.
//
// Signed operations run on operand magnitudes. The unit records the
// result sign and the remainder sign at issue. It applies the sign fix on
// the edge that writes HI/LO. HI/LO change only on that edge, so a flushed
// or reset operation never exposes a partial result.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   EX instruction is MULT/MULTU/DIV/DIVU
//   md_op[1:0] in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op_a       in   forwarded rs (multiplicand / dividend)
//   op_b       in   forwarded rt (multiplier / divisor)
//   flush      in   EX squash; abandons any operation, HI/LO untouched
//   hi         out  HI register (product upper half / remainder)
//   lo         out  LO register (product lower half / quotient)
//   busy       out  FSM is not IDLE
//   stall_req  out  freeze PC, IF/ID and ID/EX
//   done       out  one-cycle pulse; HI/LO were written on the previous edge
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int DATA_LEN = 32,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          md_op,
  input  logic [DATA_LEN-1:0] op_a,
  input  logic [DATA_LEN-1:0] op_b,
  input  logic                flush,
  output logic [DATA_LEN-1:0] hi,
  output logic [DATA_LEN-1:0] lo,
  output logic                busy,
  output logic                stall_req,
  output logic                done
);

  localparam int W2 = 2 * DATA_LEN;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  // Shared working register.
  //   multiply: {partial product, remaining multiplier bits}
  //   divide:   {partial remainder, remaining dividend / quotient bits}
  logic [W2-1:0]       acc;
  // Multiplicand magnitude for a multiply, or divisor magnitude for a divide.
  logic [DATA_LEN-1:0] opnd;
  logic                res_neg;   // negate product or quotient at the end
  logic                rem_neg;   // negate the remainder (dividend was negative)

  // ------------------------------------------------------------------
  // Issue-time operand conditioning
  // ------------------------------------------------------------------
  logic                op_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_LEN-1:0] a_mag;
  logic [DATA_LEN-1:0] b_mag;
  logic                div_by_zero;

  assign op_signed   = ~md_op[0];
  assign a_neg       = op_signed & op_a[DATA_LEN-1];
  assign b_neg       = op_signed & op_b[DATA_LEN-1];
  // The magnitude of the most negative value wraps to itself. Read as
  // unsigned, that value is the correct magnitude.
  assign a_mag       = a_neg ? (~op_a + 1'b1) : op_a;
  assign b_mag       = b_neg ? (~op_b + 1'b1) : op_b;
  assign div_by_zero = md_op[1] & (op_b == '0);

  // ------------------------------------------------------------------
  // Multiply step: add the multiplicand when the current multiplier LSB is
  // set, then shift right. The adder carry becomes the new top bit.
  // ------------------------------------------------------------------
  logic [DATA_LEN:0] mul_sum;
  logic [W2-1:0]     mul_next;
  logic [W2-1:0]     mul_fixed;

  assign mul_sum   = {1'b0, acc[W2-1:DATA_LEN]}
                   + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc[DATA_LEN-1:1]};
  assign mul_fixed = res_neg ? (~mul_next + 1'b1) : mul_next;

  // ------------------------------------------------------------------
  // Restoring divide step: shift in the next dividend bit, then try the
  // subtraction. A clear borrow bit means remainder >= divisor. The
  // invariant remainder < divisor keeps the shifted value below
  // 2*divisor, so the (DATA_LEN+1)-bit difference cannot overflow.
  // ------------------------------------------------------------------
  logic [DATA_LEN:0]   rem_sh;
  logic [DATA_LEN:0]   div_diff;
  logic                q_bit;
  logic [DATA_LEN-1:0] rem_new;
  logic [W2-1:0]       div_next;
  logic [DATA_LEN-1:0] quo_fixed;
  logic [DATA_LEN-1:0] rem_fixed;

  assign rem_sh    = {acc[W2-1:DATA_LEN], acc[DATA_LEN-1]};
  assign div_diff  = rem_sh - {1'b0, opnd};
  assign q_bit     = ~div_diff[DATA_LEN];
  assign rem_new   = q_bit ? div_diff[DATA_LEN-1:0] : rem_sh[DATA_LEN-1:0];
  assign div_next  = {rem_new, acc[DATA_LEN-2:0], q_bit};
  assign quo_fixed = res_neg ? (~div_next[DATA_LEN-1:0] + 1'b1)
                             : div_next[DATA_LEN-1:0];
  assign rem_fixed = rem_neg ? (~div_next[W2-1:DATA_LEN] + 1'b1)
                             : div_next[W2-1:DATA_LEN];

  logic last_iter;
  assign last_iter = (cnt == CNT_W'(DATA_LEN - 1));

  // ------------------------------------------------------------------
  // Status outputs
  // ------------------------------------------------------------------
  assign busy      = (state != IDLE);
  // The stall drops in DONE, so the instruction behind the mul/div moves
  // into EX in the cycle right after the result is written.
  assign stall_req = ((state == IDLE) & start & ~flush)
                   | (state == MUL_RUN) | (state == DIV_RUN);

  // ------------------------------------------------------------------
  // FSM and datapath registers
  // ------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignments. Each
  // right-hand side then reads the value from before the edge, which is
  // what the iteration math relies on.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the working registers are reset along with the visible state.
      // After an abort, no stale operand or sign bit can then affect a later
      // operation.
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            res_neg <= a_neg ^ b_neg;
            rem_neg <= md_op[1] & a_neg;
            if (div_by_zero) begin
              lo    <= '1;
              hi    <= op_a;
              done  <= 1'b1;
              state <= DONE;
            end else if (md_op[1]) begin
              acc   <= {{DATA_LEN{1'b0}}, a_mag};
              opnd  <= b_mag;
              state <= DIV_RUN;
            end else begin
              acc   <= {{DATA_LEN{1'b0}}, b_mag};
              opnd  <= a_mag;
              state <= MUL_RUN;
            end
          end
        end

        MUL_RUN: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            {hi, lo} <= mul_fixed;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DIV_RUN: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi    <= rem_fixed;
            lo    <= quo_fixed;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        // start is ignored here: the instruction that is still held in EX
        // must not be issued a second time.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Scoreboard bench for ex_muldiv_unit. Each issued operation pushes its
// expected {hi,lo} onto a queue. A monitor pops and compares the entry
// whenever done pulses. The issuing task also checks latency, the
// stall_req cycle count and that hi/lo still hold the previous result.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   md_op;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         flush;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         busy;
  logic         stall_req;
  logic         done;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_LEN(N), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .md_op     (md_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done)
  );

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          n_ops    = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_hl;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model built on native arithmetic. The bench computes the
  // expected {hi,lo} from this for the random operations.
  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sq;
    logic signed [63:0] sr;
    logic [63:0]        res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      check("queue_depth_at_done", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) check("result_hilo", {hi, lo}, exp_q.pop_front());
    end
  end

  // Issues one operation. start stays high until the DONE cycle, as a
  // stalled pipeline would hold it.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_hl, input int exp_lat,
                        input int exp_stall);
    int lat;
    int stalls;
    bit seen;
    exp_q.push_back(exp_hl);
    n_ops++;
    @(negedge clk);
    start = 1'b1; flush = 1'b0; md_op = op; op_a = a; op_b = b;
    #1;
    check({tag, "_hilo_at_issue"}, {hi, lo}, last_hl);
    check({tag, "_done_at_issue"}, 64'(done), 64'd0);
    lat = 0; stalls = 0; seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      lat++;
      if (stall_req) stalls++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
    last_hl = exp_hl;
  endtask

  task automatic go_idle(input string tag);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_stall"}, 64'(stall_req), 64'd0);
    check({tag, "_idle_done"}, 64'(done), 64'd0);
  endtask

  // Starts MULT 6*7, then kills it with flush or rst in run cycle 10.
  task automatic abort_mult(input string tag, input bit use_rst,
                            input logic [63:0] exp_hl);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; flush = 1'b0; md_op = 2'b00; op_a = 32'd6; op_b = 32'd7;
    #1;
    check({tag, "_stall_issue"}, 64'(stall_req), 64'd1);
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    #1;
    check({tag, "_busy_run10"}, 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    #1;
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_stall_after"}, 64'(stall_req), 64'd0);
    check({tag, "_hilo_after"}, {hi, lo}, exp_hl);
    repeat (40) @(negedge clk);
    #1;
    check({tag, "_no_done"}, 64'(done_cnt), 64'(d0));
    check({tag, "_hilo_later"}, {hi, lo}, exp_hl);
    last_hl = exp_hl;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          r_lat;

    rst = 1'b1; start = 1'b0; flush = 1'b0; md_op = 2'b00;
    op_a = '0; op_b = '0; last_hl = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5,
           64'hFFFF_FFFF_FFFF_FFF1, 34, 33);
    go_idle("mult_neg3x5");
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, 34, 33);
    go_idle("multu_max");
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 34, 33);
    go_idle("div_neg7_2");
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7,
           64'h0000_0002_0000_000E, 34, 33);
    go_idle("divu_100_7");
    run_op("divu_by_zero", 2'b11, 32'h1234_5678, 32'd0,
           64'h1234_5678_FFFF_FFFF, 2, 1);
    go_idle("divu_by_zero");
    run_op("div_by_zero", 2'b10, 32'hFFFF_FFF0, 32'd0,
           64'hFFFF_FFF0_FFFF_FFFF, 2, 1);
    go_idle("div_by_zero");
    run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000, 34, 33);
    go_idle("div_overflow");
    run_op("div_neg100_7", 2'b10, 32'hFFFF_FF9C, 32'd7,
           64'hFFFF_FFFE_FFFF_FFF2, 34, 33);
    go_idle("div_neg100_7");
    run_op("div_100_neg7", 2'b10, 32'd100, 32'hFFFF_FFF9,
           64'h0000_0002_FFFF_FFF2, 34, 33);
    go_idle("div_100_neg7");

    // A flush in IDLE while start is high must not begin an operation.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; md_op = 2'b01; op_a = 32'd9; op_b = 32'd9;
    #1;
    check("flush_idle_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_idle_hilo", {hi, lo}, last_hl);

    // Preload hi=0xAA, lo=0xBB: 0xBBAA / 0x100 = 0xBB remainder 0xAA.
    run_op("preload", 2'b11, 32'h0000_BBAA, 32'h0000_0100,
           64'h0000_00AA_0000_00BB, 34, 33);
    go_idle("preload");
    abort_mult("flush_abort", 1'b0, 64'h0000_00AA_0000_00BB);
    abort_mult("rst_abort", 1'b1, 64'd0);

    // Back-to-back: start is held continuously from one op into the next.
    run_op("b2b_multu", 2'b01, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 34, 33);
    run_op("b2b_divu", 2'b11, 32'd9, 32'd2, 64'h0000_0001_0000_0004, 34, 33);
    go_idle("b2b");

    for (int i = 0; i < 8; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = (i == 5) ? 32'd0 : $urandom;
      if (i == 2) r_b = 32'($urandom_range(1, 255));
      r_lat = (r_op[1] && r_b == 32'd0) ? 2 : 34;
      run_op("random", r_op, r_a, r_b, model(r_op, r_a, r_b), r_lat, r_lat - 1);
      go_idle("random");
    end

    repeat (3) @(negedge clk);
    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    check("done_pulse_total", 64'(done_cnt), 64'(n_ops));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
